// File: rtl/reg_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_master_pkg
// Purpose : Shared widths, the unmapped-address read pattern and the state
//           encoding of the register-bus initiator.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package reg_bus_master_pkg;

    localparam int          c_REGBUS_AW = 10;
    localparam int          c_REGBUS_DW = 32;
    localparam logic [31:0] c_BAD_PATT  = 32'hbadace55;
    localparam int          c_STATE_W   = 2;
    localparam int          c_ERRCNT_W  = 16;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    // Saturating increment for the timeout counter: sticks at all-ones.
    function automatic logic [c_ERRCNT_W-1:0] sat_inc(input logic [c_ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_master
// Purpose : Register-bus initiator. Takes one host command at a time, runs
//           one val/ready bus transaction and returns the read (or readback)
//           data, or a timeout error, on a held response stream.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           cmd_valid/ready/write/addr/wdata - host command stream
//           rsp_valid/ready/rdata/err/unmapped - host response stream
//           err_cnt                   - saturating timeout count
//           val/addr/write/wdata      - bus request (stable while val)
//           rdata/ready               - bus response
// Revision: 1.0 - initial release
// ============================================================================
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] BAD_PATT = c_BAD_PATT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [c_REGBUS_AW-1:0] cmd_addr,
    input  logic [c_REGBUS_DW-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [c_REGBUS_DW-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_unmapped,
    output logic [c_ERRCNT_W-1:0]  err_cnt,
    output logic                   val,
    output logic [c_REGBUS_AW-1:0] addr,
    output logic                   write,
    output logic [c_REGBUS_DW-1:0] wdata,
    input  logic [c_REGBUS_DW-1:0] rdata,
    input  logic                   ready
);

    // Counter is sized so that TIMEOUT-1 is its terminal value; it never wraps.
    localparam int                 c_TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    state_e                   r_state_q,        w_state_d;
    logic                     r_val_q,          w_val_d;
    logic [c_REGBUS_AW-1:0]   r_addr_q,         w_addr_d;
    logic                     r_write_q,        w_write_d;
    logic [c_REGBUS_DW-1:0]   r_wdata_q,        w_wdata_d;
    logic [c_TMO_W-1:0]       r_tmo_q,          w_tmo_d;
    logic                     r_rsp_valid_q,    w_rsp_valid_d;
    logic [c_REGBUS_DW-1:0]   r_rsp_rdata_q,    w_rsp_rdata_d;
    logic                     r_rsp_err_q,      w_rsp_err_d;
    logic                     r_rsp_unmapped_q, w_rsp_unmapped_d;
    logic [c_ERRCNT_W-1:0]    r_err_cnt_q,      w_err_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q        <= S_IDLE;
            r_val_q          <= 1'b0;
            r_addr_q         <= '0;
            r_write_q        <= 1'b0;
            r_wdata_q        <= '0;
            r_tmo_q          <= '0;
            r_rsp_valid_q    <= 1'b0;
            r_rsp_rdata_q    <= '0;
            r_rsp_err_q      <= 1'b0;
            r_rsp_unmapped_q <= 1'b0;
            r_err_cnt_q      <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_val_q          <= w_val_d;
            r_addr_q         <= w_addr_d;
            r_write_q        <= w_write_d;
            r_wdata_q        <= w_wdata_d;
            r_tmo_q          <= w_tmo_d;
            r_rsp_valid_q    <= w_rsp_valid_d;
            r_rsp_rdata_q    <= w_rsp_rdata_d;
            r_rsp_err_q      <= w_rsp_err_d;
            r_rsp_unmapped_q <= w_rsp_unmapped_d;
            r_err_cnt_q      <= w_err_cnt_d;
        end
    end

    always_comb begin
        w_state_d        = r_state_q;
        w_val_d          = r_val_q;
        w_addr_d         = r_addr_q;
        w_write_d        = r_write_q;
        w_wdata_d        = r_wdata_q;
        w_tmo_d          = r_tmo_q;
        w_rsp_valid_d    = r_rsp_valid_q;
        w_rsp_rdata_d    = r_rsp_rdata_q;
        w_rsp_err_d      = r_rsp_err_q;
        w_rsp_unmapped_d = r_rsp_unmapped_q;
        w_err_cnt_d      = r_err_cnt_q;
        cmd_ready        = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                // A responder still holding ready from the previous transaction
                // would otherwise complete the next request instantly.
                cmd_ready = !ready;
                if (cmd_valid && !ready) begin
                    w_addr_d  = cmd_addr;
                    w_write_d = cmd_write;
                    w_wdata_d = cmd_wdata;
                    w_val_d   = 1'b1;
                    w_tmo_d   = '0;
                    w_state_d = S_REQ;
                end
            end
            S_REQ: begin
                // ready is checked first so a response on the last allowed
                // cycle still completes without error.
                if (ready) begin
                    w_rsp_rdata_d    = rdata;
                    w_rsp_err_d      = 1'b0;
                    w_rsp_unmapped_d = !r_write_q && (rdata == BAD_PATT);
                    w_val_d          = 1'b0;
                    w_rsp_valid_d    = 1'b1;
                    w_state_d        = S_RSP;
                end else if (r_tmo_q == c_TMO_LAST) begin
                    w_rsp_rdata_d    = '0;
                    w_rsp_err_d      = 1'b1;
                    w_rsp_unmapped_d = 1'b0;
                    w_err_cnt_d      = sat_inc(r_err_cnt_q);
                    w_val_d          = 1'b0;
                    w_rsp_valid_d    = 1'b1;
                    w_state_d        = S_RSP;
                end else begin
                    w_tmo_d = r_tmo_q + 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_state_d     = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_val_d   = 1'b0;
            end
        endcase
    end

    assign val          = r_val_q;
    assign addr         = r_addr_q;
    assign write        = r_write_q;
    assign wdata        = r_wdata_q;
    assign rsp_valid    = r_rsp_valid_q;
    assign rsp_rdata    = r_rsp_rdata_q;
    assign rsp_err      = r_rsp_err_q;
    assign rsp_unmapped = r_rsp_unmapped_q;
    assign err_cnt      = r_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bus_master
// Purpose : Self-checking bench for reg_bus_master with a small behavioural
//           register-block responder (16 registers at 0x300-0x30F, others
//           read as the bad pattern; writes return the previous contents).
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_bus_master;

    localparam int          c_TIMEOUT = 8;
    localparam logic [31:0] c_BAD     = 32'hbadace55;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [9:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_unmapped;
    logic [31:0] rsp_rdata;
    logic [15:0] err_cnt;
    logic        val, write, ready;
    logic [9:0]  addr;
    logic [31:0] wdata, rdata;

    always #5 clk = ~clk;

    reg_bus_master #(.TIMEOUT(c_TIMEOUT), .BAD_PATT(c_BAD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_unmapped(rsp_unmapped), .err_cnt(err_cnt),
        .val(val), .addr(addr), .write(write), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    // ---------------- responder ----------------
    logic        stuck = 1'b0;      // never answers
    logic        slow_drop = 1'b0;  // keeps ready high 2 extra cycles after val falls
    logic [31:0] mem [16];
    logic [1:0]  hold;

    always @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
            hold  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (val && !stuck) begin
            ready <= 1'b1;
            hold  <= slow_drop ? 2'd2 : 2'd0;
            if (!ready) begin
                if (addr[9:4] == 6'h30) begin
                    rdata <= mem[addr[3:0]];
                    if (write) mem[addr[3:0]] <= wdata;
                end else begin
                    rdata <= c_BAD;
                end
            end
        end else if (hold != 2'd0) begin
            hold <= hold - 2'd1;
        end else begin
            ready <= 1'b0;
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int acc_q[$];
    int guard_viol = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (cmd_ready && ready) guard_viol++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
    endtask

    task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input string nm, output bit ok);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        ok = cmd_ready;
        if (!ok) bound_fail({nm, "_accept"});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input string nm, output logic [31:0] rd,
                           output logic e, output logic u);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        if (!rsp_valid) bound_fail({nm, "_rsp"});
        rd = rsp_rdata; e = rsp_err; u = rsp_unmapped;
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_unm;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic [31:0] rd;
        logic        e, u;
        bit          ok;
        int          cnt, n, base;

        vecs[0] = '{1'b1, 10'h300, 32'h00000001, 32'h00000000, 1'b0};
        vecs[1] = '{1'b0, 10'h300, 32'h0,        32'h00000001, 1'b0};
        vecs[2] = '{1'b0, 10'h3FC, 32'h0,        32'hbadace55, 1'b1};
        vecs[3] = '{1'b1, 10'h305, 32'hbadace55, 32'h00000000, 1'b0};
        vecs[4] = '{1'b0, 10'h305, 32'h0,        32'hbadace55, 1'b1};
        vecs[5] = '{1'b1, 10'h305, 32'h12345678, 32'hbadace55, 1'b0};
        vecs[6] = '{1'b0, 10'h305, 32'h0,        32'h12345678, 1'b0};
        vecs[7] = '{1'b1, 10'h3FC, 32'hffffffff, 32'hbadace55, 1'b0};
        vecs[8] = '{1'b0, 10'h000, 32'h0,        32'hbadace55, 1'b1};
        vecs[9] = '{1'b0, 10'h300, 32'h0,        32'h00000001, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_val", {31'd0, val}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_addr", {22'd0, addr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_err, rsp_unmapped}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Table-driven transactions
        foreach (vecs[i]) begin
            issue(vecs[i].wr, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i), ok);
            collect($sformatf("vec%0d", i), rd, e, u);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, 32'd0);
            chk($sformatf("vec%0d_unmapped", i), {31'd0, u}, {31'd0, vecs[i].exp_unm});
        end
        @(negedge clk);
        chk("idle_addr_hold", {22'd0, addr}, 32'h300);
        chk("idle_write_hold", {31'd0, write}, 32'd0);

        // Timeout: val high for exactly TIMEOUT cycles
        stuck = 1'b1;
        issue(1'b0, 10'h301, 32'h0, "tmo", ok);
        cnt = 0; n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            if (val) cnt++;
            @(negedge clk); n++;
        end
        if (!rsp_valid) bound_fail("tmo_wait");
        chk("tmo_val_cycles", cnt, c_TIMEOUT);
        collect("tmo", rd, e, u);
        chk("tmo_err", {31'd0, e}, 32'd1);
        chk("tmo_rdata", rd, 32'd0);
        chk("tmo_unmapped", {31'd0, u}, 32'd0);
        chk("tmo_err_cnt", {16'd0, err_cnt}, 32'd1);
        stuck = 1'b0;

        // Held response: stable, no new command accepted
        issue(1'b0, 10'h300, 32'h0, "hold", ok);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp_valid) bound_fail("hold_wait");
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h302; cmd_wdata = 32'ha5a5a5a5;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("hold%0d_rsp_rdata", k), rsp_rdata, 32'h1);
            chk($sformatf("hold%0d_cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) bound_fail("pending_accept");
        @(posedge clk); #1 cmd_valid = 1'b0;
        collect("pending", rd, e, u);
        chk("pending_rdata", rd, 32'h0);
        issue(1'b0, 10'h302, 32'h0, "pending_rb", ok);
        collect("pending_rb", rd, e, u);
        chk("pending_rb_rdata", rd, 32'ha5a5a5a5);

        // Back-to-back accepts with normal and late-dropping ready
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            slow_drop = (s == 1);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h300; cmd_wdata = '0;
            rsp_ready = 1'b1;
            base = acc_q.size();
            n = 0;
            while (acc_q.size() < base + 3 && n < 100) begin @(negedge clk); #1; n++; end
            @(posedge clk); #1 cmd_valid = 1'b0;
            repeat (8) @(posedge clk);
            #1 rsp_ready = 1'b0;
            if (acc_q.size() < base + 3) bound_fail($sformatf("b2b%0d", s));
            else chk($sformatf("b2b%0d_gap", s), acc_q[base+2] - acc_q[base+1], (s == 1) ? 6 : 4);
        end
        slow_drop = 1'b0;
        chk("stale_ready_guard", guard_viol, 0);

        // Reset while in REQ
        stuck = 1'b1;
        issue(1'b0, 10'h303, 32'h0, "rstreq", ok);
        @(negedge clk);
        chk("rstreq_val_before", {31'd0, val}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstreq_val", {31'd0, val}, 32'd0);
        chk("rstreq_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rstreq_addr", {22'd0, addr}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("rstreq_no_rsp", cnt, 0);

        // err_cnt saturation: preload near the top, then keep timing out
        @(posedge clk); #1 force dut.r_err_cnt_q = 16'hFFFD;
        @(posedge clk); #1 release dut.r_err_cnt_q;
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 10'h304, 32'h0, "sat", ok);
            collect("sat", rd, e, u);
            chk($sformatf("sat%0d_err", k), {31'd0, e}, 32'd1);
            chk($sformatf("sat%0d_err_cnt", k), {16'd0, err_cnt},
                (k == 0) ? 32'hFFFE : 32'hFFFF);
        end
        stuck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
